sram_mem_ctrl: RTL and testbench

- Parametrised data-memory controller for the 5-stage ARM pipeline. It replaces the single-cycle data memory in the MEM stage with an external SRAM access.
- Converts a DATA_W-bit load/store into RATIO narrow SRAM beats, each with programmable wait states.
- Asserts freeze to stall all pipeline stages until the access completes.

---
 rtl/sram_mem_ctrl.sv | 151 +++++++++++++++
 tb/tb_sram_mem_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_ctrl.sv
// Data-memory controller for the MEM stage: splits each CPU load/store into
// narrow SRAM beats with programmable wait states and freezes the pipeline meanwhile.
module sram_mem_ctrl #(
    parameter int DATA_W      = 32,
    parameter int SRAM_DATA_W = 16,
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 5,
    parameter int BASE_ADDR   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic [31:0]            addr,
    input  logic [DATA_W-1:0]      wdata,
    output logic [DATA_W-1:0]      rdata,
    output logic                   ready,
    output logic                   freeze,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_we_n,
    output logic                   sram_oe_n
);

    localparam int RATIO    = DATA_W / SRAM_DATA_W;
    localparam int BYTE_SH  = $clog2(DATA_W / 8);
    localparam int RATIO_SH = $clog2(RATIO);
    localparam int BEAT_W   = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int WAIT_W   = $clog2(WAIT_CYCLES + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(WAIT_CYCLES);
    localparam logic [WAIT_W-1:0] PRE_WAIT  = WAIT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                 state;
    logic [BEAT_W-1:0]      beat;
    logic [WAIT_W-1:0]      wait_cnt;
    logic                   is_write;
    logic [DATA_W-1:0]      wdata_q;
    logic [DATA_W-1:0]      rbuf;
    logic [DATA_W-1:0]      assembled;
    logic [31:0]            byte_off;
    logic [SRAM_ADDR_W-1:0] start_word;

    assign byte_off   = addr - 32'(BASE_ADDR);
    assign start_word = SRAM_ADDR_W'((byte_off >> BYTE_SH) << RATIO_SH);

    // Read beats shift in from the top, so after RATIO beats beat 0 lands in the LSBs.
    always_comb begin
        assembled = (rbuf >> SRAM_DATA_W) | (DATA_W'(sram_dq_in) << (DATA_W - SRAM_DATA_W));
    end

    assign freeze = rst && (((state == IDLE) && (mem_r_en || mem_w_en)) || (state == ACCESS));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            beat        <= '0;
            wait_cnt    <= '0;
            is_write    <= 1'b0;
            wdata_q     <= '0;
            rbuf        <= '0;
            rdata       <= '0;
            ready       <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    if (mem_w_en || mem_r_en) begin
                        state     <= ACCESS;
                        beat      <= '0;
                        wait_cnt  <= '0;
                        sram_addr <= start_word;
                        is_write  <= mem_w_en;
                        if (mem_w_en) begin
                            wdata_q     <= wdata >> SRAM_DATA_W;
                            sram_dq_out <= wdata[SRAM_DATA_W-1:0];
                            sram_dq_oe  <= 1'b1;
                            sram_we_n   <= 1'b0;
                            sram_oe_n   <= 1'b1;
                        end else begin
                            wdata_q     <= '0;
                            sram_dq_out <= '0;
                            sram_dq_oe  <= 1'b0;
                            sram_we_n   <= 1'b1;
                            sram_oe_n   <= 1'b0;
                        end
                    end
                end

                ACCESS: begin
                    if (wait_cnt == LAST_WAIT) begin
                        if (!is_write) begin
                            rbuf <= assembled;
                        end
                        if (beat == LAST_BEAT) begin
                            state      <= DONE;
                            ready      <= 1'b1;
                            beat       <= '0;
                            wait_cnt   <= '0;
                            sram_dq_oe <= 1'b0;
                            sram_we_n  <= 1'b1;
                            sram_oe_n  <= 1'b1;
                            if (!is_write) begin
                                rdata <= assembled;
                            end
                        end else begin
                            beat      <= beat + BEAT_W'(1);
                            wait_cnt  <= '0;
                            sram_addr <= sram_addr + SRAM_ADDR_W'(1);
                            if (is_write) begin
                                sram_dq_out <= wdata_q[SRAM_DATA_W-1:0];
                                wdata_q     <= wdata_q >> SRAM_DATA_W;
                                sram_we_n   <= 1'b0;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                        // Raise the write strobe one cycle early so address and data are held past it.
                        if (is_write && (wait_cnt == PRE_WAIT)) begin
                            sram_we_n <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    ready <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl: default 32/16 configuration against a small
// SRAM model, plus a 32/32 single-wait instance for the single-beat case.
module tb_sram_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        freeze;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;
    logic        sram_oe_n;

    logic        r1_r_en;
    logic        r1_w_en;
    logic [31:0] r1_addr_in;
    logic [31:0] r1_wdata;
    logic [31:0] r1_rdata;
    logic        r1_ready;
    logic        r1_freeze;
    logic [17:0] r1_sram_addr;
    logic [31:0] r1_dq_out;
    logic        r1_dq_oe;
    logic [31:0] r1_dq_in;
    logic        r1_we_n;
    logic        r1_oe_n;

    logic [15:0] mem [16];

    int compareCount;
    int failCount;

    sram_mem_ctrl dut (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .freeze(freeze),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    sram_mem_ctrl #(.DATA_W(32), .SRAM_DATA_W(32), .SRAM_ADDR_W(18), .WAIT_CYCLES(1), .BASE_ADDR(1024)) dut1 (
        .clk(clk), .rst(rst), .mem_r_en(r1_r_en), .mem_w_en(r1_w_en),
        .addr(r1_addr_in), .wdata(r1_wdata), .rdata(r1_rdata), .ready(r1_ready), .freeze(r1_freeze),
        .sram_addr(r1_sram_addr), .sram_dq_out(r1_dq_out), .sram_dq_oe(r1_dq_oe),
        .sram_dq_in(r1_dq_in), .sram_we_n(r1_we_n), .sram_oe_n(r1_oe_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: combinational read while OE is low, write on each clock with WE low.
    assign sram_dq_in = sram_oe_n ? 16'h0000 : mem[sram_addr[3:0]];
    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr[3:0]] <= sram_dq_out;
    end

    assign r1_dq_in = (!r1_oe_n && r1_sram_addr == 18'd1) ? 32'h0BADCAFE : 32'h0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expected);
        compareCount++;
        if (got !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        mem_r_en = r;
        mem_w_en = w;
        addr     = a;
        wdata    = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        compareCount = 0;
        failCount    = 0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        mem[2] = 16'h5678;
        mem[3] = 16'h1234;
        mem[7] = 16'hAAAA;
        r1_r_en = 0; r1_w_en = 0; r1_addr_in = 0; r1_wdata = 0;

        // Reset with a request present: freeze must stay low.
        rst = 0;
        applyStimulus(1, 0, 32'd1024, 32'h0);
        tick(); tick();
        checkOutput("rst_freeze", 64'(freeze), 64'd0);
        checkOutput("rst_ready", 64'(ready), 64'd0);
        checkOutput("rst_we_n", 64'(sram_we_n), 64'd1);
        checkOutput("rst_oe_n", 64'(sram_oe_n), 64'd1);
        checkOutput("rst_dq_oe", 64'(sram_dq_oe), 64'd0);
        checkOutput("rst_addr", 64'(sram_addr), 64'd0);
        checkOutput("rst_dq_out", 64'(sram_dq_out), 64'd0);
        checkOutput("rst_rdata", 64'(rdata), 64'd0);
        applyStimulus(0, 0, 32'd0, 32'h0);
        rst = 1;
        tick();
        checkOutput("idle_freeze", 64'(freeze), 64'd0);

        // Store 0xDEADBEEF at 1024, enable held through DONE.
        applyStimulus(0, 1, 32'd1024, 32'hDEADBEEF);
        #1;
        checkOutput("st_c0_freeze", 64'(freeze), 64'd1);
        for (int c = 1; c <= 12; c++) begin
            tick();
            checkOutput("st_addr", 64'(sram_addr), (c <= 6) ? 64'd0 : 64'd1);
            checkOutput("st_dq_out", 64'(sram_dq_out), (c <= 6) ? 64'hBEEF : 64'hDEAD);
            checkOutput("st_we_n", 64'(sram_we_n), (c == 6 || c == 12) ? 64'd1 : 64'd0);
            checkOutput("st_oe_n", 64'(sram_oe_n), 64'd1);
            checkOutput("st_dq_oe", 64'(sram_dq_oe), 64'd1);
            checkOutput("st_freeze", 64'(freeze), 64'd1);
            checkOutput("st_ready", 64'(ready), 64'd0);
        end
        tick();
        checkOutput("st_c13_ready", 64'(ready), 64'd1);
        checkOutput("st_c13_freeze", 64'(freeze), 64'd0);
        checkOutput("st_c13_we_n", 64'(sram_we_n), 64'd1);
        checkOutput("st_rdata_kept", 64'(rdata), 64'd0);
        applyStimulus(0, 0, 32'd0, 32'h0);
        tick();
        checkOutput("st_c14_ready", 64'(ready), 64'd0);
        checkOutput("st_mem0", 64'(mem[0]), 64'hBEEF);
        checkOutput("st_mem1", 64'(mem[1]), 64'hDEAD);

        // Load from 1028, read enable held through DONE and into the next IDLE.
        applyStimulus(1, 0, 32'd1028, 32'h0);
        #1;
        checkOutput("ld_c0_freeze", 64'(freeze), 64'd1);
        for (int c = 1; c <= 12; c++) begin
            tick();
            checkOutput("ld_addr", 64'(sram_addr), (c <= 6) ? 64'd2 : 64'd3);
            checkOutput("ld_oe_n", 64'(sram_oe_n), 64'd0);
            checkOutput("ld_we_n", 64'(sram_we_n), 64'd1);
            checkOutput("ld_dq_oe", 64'(sram_dq_oe), 64'd0);
            checkOutput("ld_ready", 64'(ready), 64'd0);
            checkOutput("ld_rdata_hold", 64'(rdata), 64'd0);
        end
        tick();
        checkOutput("ld_c13_ready", 64'(ready), 64'd1);
        checkOutput("ld_c13_rdata", 64'(rdata), 64'h12345678);
        checkOutput("ld_c13_freeze", 64'(freeze), 64'd0);
        tick();
        checkOutput("ld_c14_oe_n", 64'(sram_oe_n), 64'd1);
        checkOutput("ld_c14_ready", 64'(ready), 64'd0);
        checkOutput("ld_c14_freeze", 64'(freeze), 64'd1);
        tick();
        checkOutput("ld_c15_oe_n", 64'(sram_oe_n), 64'd0);
        checkOutput("ld_c15_addr", 64'(sram_addr), 64'd2);
        for (int c = 16; c <= 27; c++) begin
            tick();
            checkOutput("ld2_ready", 64'(ready), (c == 27) ? 64'd1 : 64'd0);
        end
        checkOutput("ld2_rdata", 64'(rdata), 64'h12345678);
        applyStimulus(0, 0, 32'd0, 32'h0);
        tick();

        // Both enables high: write wins, no read strobes, rdata untouched.
        applyStimulus(1, 1, 32'd1032, 32'hCAFEF00D);
        for (int c = 1; c <= 12; c++) begin
            tick();
            checkOutput("bo_oe_n", 64'(sram_oe_n), 64'd1);
            checkOutput("bo_dq_oe", 64'(sram_dq_oe), 64'd1);
            checkOutput("bo_addr", 64'(sram_addr), (c <= 6) ? 64'd4 : 64'd5);
        end
        tick();
        checkOutput("bo_ready", 64'(ready), 64'd1);
        checkOutput("bo_rdata", 64'(rdata), 64'h12345678);
        applyStimulus(0, 0, 32'd0, 32'h0);
        tick();
        checkOutput("bo_mem4", 64'(mem[4]), 64'hF00D);
        checkOutput("bo_mem5", 64'(mem[5]), 64'hCAFE);

        // Reset during cycle 4 of a store to 1036: beat 1 (word 7) never written.
        applyStimulus(0, 1, 32'd1036, 32'h11112222);
        for (int c = 1; c <= 4; c++) tick();
        checkOutput("mr_c4_addr", 64'(sram_addr), 64'd6);
        rst = 0;
        #1;
        checkOutput("mr_c4_freeze", 64'(freeze), 64'd0);
        tick();
        checkOutput("mr_c5_we_n", 64'(sram_we_n), 64'd1);
        checkOutput("mr_c5_freeze", 64'(freeze), 64'd0);
        checkOutput("mr_c5_ready", 64'(ready), 64'd0);
        rst = 1;
        applyStimulus(0, 0, 32'd0, 32'h0);
        for (int c = 6; c <= 20; c++) begin
            tick();
            checkOutput("mr_ready", 64'(ready), 64'd0);
            checkOutput("mr_we_n", 64'(sram_we_n), 64'd1);
        end
        checkOutput("mr_mem7", 64'(mem[7]), 64'hAAAA);

        // Single-beat instance, one wait cycle: load from 1028 -> SRAM word 1.
        r1_r_en = 1; r1_addr_in = 32'd1028;
        #1;
        checkOutput("r1_c0_freeze", 64'(r1_freeze), 64'd1);
        for (int c = 1; c <= 2; c++) begin
            tick();
            checkOutput("r1_addr", 64'(r1_sram_addr), 64'd1);
            checkOutput("r1_oe_n", 64'(r1_oe_n), 64'd0);
            checkOutput("r1_we_n", 64'(r1_we_n), 64'd1);
            checkOutput("r1_dq_oe", 64'(r1_dq_oe), 64'd0);
            checkOutput("r1_ready", 64'(r1_ready), 64'd0);
            checkOutput("r1_freeze", 64'(r1_freeze), 64'd1);
        end
        tick();
        checkOutput("r1_c3_ready", 64'(r1_ready), 64'd1);
        checkOutput("r1_c3_rdata", 64'(r1_rdata), 64'h0BADCAFE);
        checkOutput("r1_c3_freeze", 64'(r1_freeze), 64'd0);
        checkOutput("r1_dq_out", 64'(r1_dq_out), 64'd0);
        r1_r_en = 0;
        tick();
        checkOutput("r1_c4_ready", 64'(r1_ready), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
